// File: rtl/ula_pipe.sv
// Registered EX-stage ALU (add/sub/and/or/sll/srl/slt, op 7 = shift-add mul when ULA_MUL_EN is defined).
// Latency: ops 0-6 one edge; mul WIDTH edges after acceptance (without ULA_MUL_EN op 7 yields 0 in one edge).
// Backpressure: result held while out_valid && !out_ready; in_ready low while holding or multiplying.
module ula_pipe #(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         operation,
    input  logic [WIDTH-1:0]   reg1,
    input  logic [WIDTH-1:0]   reg2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               zeroFlag
);

    logic [WIDTH-1:0] alu_res;
    logic             accept;

    always_comb begin
        alu_res = '0;
        unique case (operation)
            3'd0:    alu_res = reg1 + reg2;
            3'd1:    alu_res = reg1 - reg2;
            3'd2:    alu_res = reg1 & reg2;
            3'd3:    alu_res = reg1 | reg2;
            3'd4:    alu_res = reg2 << shamt;
            3'd5:    alu_res = reg2 >> shamt;
            3'd6:    alu_res = (reg1 < reg2) ? '1 : '0;
            default: alu_res = '0;
        endcase
    end

`ifdef ULA_MUL_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   acc_next;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            zeroFlag  <= 1'b1;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (operation == 3'd7) begin
                            // Output slot is already free: acceptance implies it was empty or retiring.
                            mcand     <= reg1;
                            mplier    <= reg2;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= BUSY;
                        end else begin
                            out       <= alu_res;
                            zeroFlag  <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHAMT_W'(WIDTH - 1)) begin
                        out       <= acc_next;
                        zeroFlag  <= (acc_next == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zeroFlag  <= 1'b1;
        end else if (accept) begin
            out       <= alu_res;
            zeroFlag  <= (alu_res == '0);
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ula_pipe.sv
// Bench for ula_pipe (WIDTH = 32): directed scenarios plus randomized traffic against a behavioural model.
module tb_ula_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  operation = 3'd0;
    logic [31:0] reg1 = '0;
    logic [31:0] reg2 = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        zeroFlag;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef ULA_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    ula_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .operation(operation), .reg1(reg1), .reg2(reg2), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .zeroFlag(zeroFlag)
    );

    always #5 clk = ~clk;

    // Behavioural model: output slot contents plus remaining multiply cycles.
    bit          m_valid = 1'b0;
    logic [31:0] m_out   = '0;
    int          m_busy  = 0;
    logic [31:0] m_prod  = '0;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return b << sh;
            3'd5: return b >> sh;
            3'd6: return (a < b) ? 32'hFFFF_FFFF : 32'h0;
            default: return MUL_EN ? p[31:0] : 32'h0;
        endcase
    endfunction

    function automatic bit m_ready();
        return (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_busy  = 0;
    endtask

    // Advance one clock edge, keeping the model in step, and return at the following negedge.
    task automatic tick();
        bit acc;
        acc = in_valid && m_ready();
        @(posedge clk);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_valid = 1'b1;
                m_out   = m_prod;
            end
        end else if (acc) begin
            if (MUL_EN && operation == 3'd7) begin
                m_busy  = 32;
                m_prod  = ref_alu(operation, reg1, reg2, shamt);
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_out   = ref_alu(operation, reg1, reg2, shamt);
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        in_valid  = 1'b1;
        operation = op;
        reg1      = a;
        reg2      = b;
        shamt     = sh;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (out !== 32'h0) begin n_fail++; $display("FAIL reset_out got %h want 00000000", out); end
        n_cmp++;
        if (zeroFlag !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zeroFlag); end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd6};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd3, 32'd7};
        logic [31:0] bs  [5] = '{32'd1, 32'd3, 32'd1, 32'd7, 32'd3};
        logic [4:0]  shs [5] = '{5'd0, 5'd0, 5'd31, 5'd0, 5'd0};
        logic [31:0] exp [5] = '{32'h0, 32'h2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], shs[i]);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d got valid=%b out=%h want valid=1 out=%h", i, out_valid, out, exp[i]);
            end
            n_cmp++;
            if (zeroFlag !== (exp[i] == 32'h0) || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_flags_%0d got zero=%b in_ready=%b want zero=%b in_ready=1",
                         i, zeroFlag, in_ready, exp[i] == 32'h0);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got valid=%b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(3'd2, 32'hF0, 32'h3C, 5'd0);
        tick();
        issue(3'd0, 32'd10, 32'd20, 5'd0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out !== 32'h30 || in_ready !== 1'b0 || zeroFlag !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d got valid=%b out=%h in_ready=%b zero=%b want 1/00000030/0/0",
                         i, out_valid, out, in_ready, zeroFlag);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b want 1", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 32'd30) begin
            n_fail++;
            $display("FAIL retire_accept got valid=%b out=%h want 1/0000001e", out_valid, out);
        end
        in_valid = 1'b0;
        tick();
    endtask

`ifdef ULA_MUL_EN
    task automatic test_mul();
        logic [31:0] as  [2] = '{32'h0001_0003, 32'hFFFF_FFFF};
        logic [31:0] bs  [2] = '{32'h5, 32'h2};
        logic [31:0] exp [2] = '{32'h0005_000F, 32'hFFFF_FFFE};
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            issue(3'd7, as[t], bs[t], 5'd0);
            tick();
            in_valid = 1'b0;
            for (int i = 1; i < 32; i++) begin
                n_cmp++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mul_busy_%0d_%0d got valid=%b in_ready=%b want 0/0", t, i, out_valid, in_ready);
                end
                tick();
            end
            n_cmp++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_early_%0d got valid=%b want 0", t, out_valid); end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out !== exp[t] || zeroFlag !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_result_%0d got valid=%b out=%h zero=%b want 1/%h/0", t, out_valid, out, zeroFlag, exp[t]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        issue(3'd7, 32'd1234, 32'd5678, 5'd0);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_%0d got valid=%b want 0", i, out_valid); end
            tick();
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", in_ready); end
        issue(3'd0, 32'd1, 32'd1, 5'd0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 32'd2) begin
            n_fail++;
            $display("FAIL post_abort_add got valid=%b out=%h want 1/00000002", out_valid, out);
        end
        in_valid = 1'b0;
        tick();
    endtask
`else
    task automatic test_mul_disabled();
        out_ready = 1'b1;
        issue(3'd7, 32'd6, 32'd7, 5'd0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 32'h0 || zeroFlag !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_off got valid=%b out=%h zero=%b want 1/00000000/1", out_valid, out, zeroFlag);
        end
        in_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            operation = 3'($urandom_range(0, 7));
            reg1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            reg2      = ($urandom_range(0, 3) == 0) ? reg1 : $urandom;
            shamt     = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if (in_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL rnd_ready_%0d got %b want %b", i, in_ready, m_ready());
            end
            tick();
            n_cmp++;
            if (out_valid !== m_valid || (m_valid && (out !== m_out || zeroFlag !== (m_out == 32'h0)))) begin
                n_fail++;
                $display("FAIL rnd_out_%0d got valid=%b out=%h zero=%b want valid=%b out=%h",
                         i, out_valid, out, zeroFlag, m_valid, m_out);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
`ifdef ULA_MUL_EN
        test_mul();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_pipe.md
# ula_pipe

Parametrised, registered ALU for the EX stage of the pipelined processor, with valid/ready handshakes on both sides. It executes the seven base operations (add, sub, and, or, sll, srl, set-less-than) with one-cycle latency. It adds an optional iterative shift-add multiplier on opcode 7 that holds off new work while busy. A registered zero flag is produced alongside every result.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4, power of two)
- SHAMT_W, derived localparam = clog2(WIDTH), shift-amount width; not user-overridable
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block accepts request this cycle
- operation  in  3  opcode: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt, 7 mul
- reg1  in  WIDTH  operand A
- reg2  in  WIDTH  operand B (shifted operand for 4/5)
- shamt  in  SHAMT_W  shift amount for 4/5
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result this cycle
- out  out  WIDTH  result
- zeroFlag  out  1  1 when out == 0

## Operation
- Accept on rising edge when in_valid && in_ready; operands, opcode and shamt captured at that edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- States: IDLE, BUSY (mul only; present only with ULA_MUL_EN).
- Ops 0–6, accepted in IDLE: result and zeroFlag written into output register at accepting edge; out_valid set; state stays IDLE.
- add/sub: modulo 2^WIDTH, carry/borrow discarded.
- sll/srl: logical shift of reg2 by shamt; zero-fill; reg1 ignored.
- slt: unsigned compare; out = all ones when reg1 < reg2, else all zeros.
- mul (op 7): accepting edge loads multiplicand = reg1, multiplier = reg2, accumulator = 0, counter = 0, state → BUSY. Each BUSY edge: if multiplier[0], accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. Result is the low WIDTH bits of the product. On the edge where counter reaches WIDTH−1, write the final accumulator (including that edge's add) to out, set out_valid, state → IDLE.
- During BUSY: in_ready = 0; out_valid = 0. The output register was freed at acceptance because acceptance requires !out_valid || out_ready.
- Output hold: while out_valid && !out_ready, out and zeroFlag stay stable and in_ready = 0.
- Simultaneous consume and accept (out_valid && out_ready && in_valid in IDLE): the old result retires and a new op is accepted at the same edge. For ops 0–6, out_valid stays 1 with new data. For mul, out_valid → 0.
- out_valid clears on an edge with out_ready && out_valid and no new 0–6 op accepted.

## Timing
- Reset (async assert, sync release on clk): state IDLE, out_valid 0, out 0, zeroFlag 1, counter 0, internal operand regs 0; in_ready 1 after release.
- Reset during BUSY aborts the multiply; no result is produced.
- Latency, ops 0–6: accept at edge k → out_valid at edge k.
- Latency, mul: accept at edge k → out_valid at edge k+WIDTH.
- Throughput: one op 0–6 per cycle when out_ready is held high. Mul blocks the input for WIDTH cycles.
- zeroFlag is always registered together with out; it is never combinational from out.

## Configuration
- ULA_MUL_EN defined: BUSY state, counter and multiplier datapath compiled in; op 7 behaves as above.
- ULA_MUL_EN undefined: no BUSY state. Op 7 completes in one cycle like ops 0–6 with out = 0, zeroFlag = 1.

## Test plan
- Reset: hold reset_n low for 3 cycles → out_valid 0, out 0, zeroFlag 1. After release → in_ready 1.
- Back-to-back ALU ops, out_ready = 1, WIDTH = 32:
  - add 0xFFFFFFFF + 1 → out 0, zeroFlag 1.
  - sub 5 − 3 → out 2.
  - sll reg2 = 1, shamt = 31 → 0x80000000.
  - slt 3 < 7 → 0xFFFFFFFF.
  - slt 7 < 3 → 0.
  - Expect one result per cycle with no bubbles.
- Backpressure: issue and 0xF0 & 0x3C with out_ready = 0 for 4 cycles → out stays 0x30 with out_valid 1 and in_ready 0 throughout. Raise out_ready with in_valid held → retire and next accept occur at the same edge.
- Multiply (ULA_MUL_EN, WIDTH = 32): 0x0001_0003 × 0x0000_0005 → out 0x0005_000F exactly 32 cycles after acceptance, with in_ready 0 during BUSY. 0xFFFFFFFF × 2 → 0xFFFFFFFE.
- Reset mid-mul: assert reset_n at BUSY cycle 10 → no out_valid afterwards. After release, an add 1 + 1 issued immediately returns 2 one edge later.
- ULA_MUL_EN undefined: op 7 with 6 × 7 → out 0, zeroFlag 1, one-cycle latency.
